// File: rtl/diff_integrator_if.sv
// Sample/result bundle for diff_integrator: difference samples in, reconstructed samples out.
interface diff_integrator_if #(
  parameter int DIN_W = 16
);
  logic signed [DIN_W-1:0] din;
  logic                    in_en;
  logic                    clr;
  logic signed [15:0]      dout;
  logic                    out_en;
  logic                    sat_flag;

  modport master (
    output din, in_en, clr,
    input  dout, out_en, sat_flag
  );

  modport slave (
    input  din, in_en, clr,
    output dout, out_en, sat_flag
  );
endinterface

// File: rtl/diff_integrator.sv
// Saturating integrator y[n] = y[n-1] + d[n] with a 2-deep enable pipeline and sticky saturation flag.
// Define DIFF_INTEGRATOR_LEAK_EN to subtract acc >>> LEAK_SHIFT each sample (leaky integrator).
module diff_integrator #(
  parameter int DIN_W      = 16,
  parameter int ACC_W      = 24,
  parameter int OUT_SHIFT  = 0,
  parameter int LEAK_SHIFT = 10
) (
  input  logic             clk,
  input  logic             rst,
  diff_integrator_if.slave bus
);

  // Two guard bits keep acc + din (and the optional leak term) exact before clamping.
  localparam int SUM_W = ACC_W + 2;

  localparam logic signed [SUM_W-1:0] SUM_HI = {3'b000, {(ACC_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SUM_LO = {3'b111, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] ACC_HI = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_LO = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] OUT_HI = {{(ACC_W-15){1'b0}}, {15{1'b1}}};
  localparam logic signed [ACC_W-1:0] OUT_LO = {{(ACC_W-15){1'b1}}, {15{1'b0}}};

  if (ACC_W < DIN_W + 2 || OUT_SHIFT < 0 || LEAK_SHIFT < 0 || LEAK_SHIFT >= ACC_W) begin : g_param_check
    $error("diff_integrator: invalid parameter combination");
  end

  logic signed [DIN_W-1:0] din_reg;
  logic                    en_reg;
  logic signed [ACC_W-1:0] acc_reg;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [ACC_W-1:0] acc_shift;
  logic signed [SUM_W-1:0] sum;
  logic                    acc_clamp;
  logic signed [15:0]      dout_reg;
  logic signed [15:0]      dout_next;
  logic                    out_clamp;
  logic                    out_en_reg;
  logic                    sat_reg;
`ifdef DIFF_INTEGRATOR_LEAK_EN
  logic signed [ACC_W-1:0] leak_term;
`endif

  always_comb begin
    sum = {{2{acc_reg[ACC_W-1]}}, acc_reg}
        + {{(SUM_W-DIN_W){din_reg[DIN_W-1]}}, din_reg};
`ifdef DIFF_INTEGRATOR_LEAK_EN
    leak_term = acc_reg >>> LEAK_SHIFT;
    sum       = sum - {{2{leak_term[ACC_W-1]}}, leak_term};
`endif

    acc_clamp = 1'b0;
    acc_next  = sum[ACC_W-1:0];
    if (sum > SUM_HI) begin
      acc_next  = ACC_HI;
      acc_clamp = 1'b1;
    end else if (sum < SUM_LO) begin
      acc_next  = ACC_LO;
      acc_clamp = 1'b1;
    end

    // Output is taken from the freshly clamped accumulator so dout tracks acc with no extra lag.
    acc_shift = acc_next >>> OUT_SHIFT;
    out_clamp = 1'b0;
    dout_next = acc_shift[15:0];
    if (acc_shift > OUT_HI) begin
      dout_next = 16'sh7fff;
      out_clamp = 1'b1;
    end else if (acc_shift < OUT_LO) begin
      dout_next = 16'sh8000;
      out_clamp = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      din_reg    <= '0;
      en_reg     <= 1'b0;
      acc_reg    <= '0;
      dout_reg   <= '0;
      out_en_reg <= 1'b0;
      sat_reg    <= 1'b0;
    end else begin
      din_reg    <= bus.din;
      en_reg     <= bus.in_en;
      out_en_reg <= en_reg;
      if (bus.clr) begin
        // The stage-2 sample is dropped; stage 1 keeps whatever it just captured.
        acc_reg <= '0;
        sat_reg <= 1'b0;
        if (en_reg) begin
          dout_reg <= '0;
        end
      end else if (en_reg) begin
        acc_reg  <= acc_next;
        dout_reg <= dout_next;
        if (acc_clamp || out_clamp) begin
          sat_reg <= 1'b1;
        end
      end
    end
  end

  assign bus.dout     = dout_reg;
  assign bus.out_en   = out_en_reg;
  assign bus.sat_flag = sat_reg;

endmodule

// File: tb/tb_diff_integrator.sv
// Directed-vector bench for diff_integrator; expected values are hand-computed per step.
module tb_diff_integrator;

  logic clk;
  logic rst;
  int   nvec;
  int   nmis;

  diff_integrator_if #(.DIN_W(16)) dif ();

`ifdef DIFF_INTEGRATOR_LEAK_EN
  diff_integrator #(.DIN_W(16), .ACC_W(24), .OUT_SHIFT(0), .LEAK_SHIFT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dif)
  );
`else
  diff_integrator #(.DIN_W(16), .ACC_W(24), .OUT_SHIFT(0), .LEAK_SHIFT(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dif)
  );
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cyc(input int d, input bit en, input bit c);
    dif.din   = 16'(d);
    dif.in_en = en;
    dif.clr   = c;
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input int exp_dout, input bit exp_en, input bit exp_sat);
    logic [17:0] obs;
    logic [17:0] exp;
    obs  = {dif.dout, dif.out_en, dif.sat_flag};
    exp  = {16'(exp_dout), exp_en, exp_sat};
    nvec = nvec + 1;
    assert (obs === exp)
    else begin
      nmis = nmis + 1;
      $error("FAIL %s: got dout=%0d out_en=%0b sat=%0b, expected dout=%0d out_en=%0b sat=%0b",
             tag, $signed(dif.dout), dif.out_en, dif.sat_flag, exp_dout, exp_en, exp_sat);
    end
  endtask

  initial begin
    int exp_v;
    bit pat [6];
    int gap_exp [5];
`ifdef DIFF_INTEGRATOR_LEAK_EN
    int leak_exp [5];
`endif
    nvec = 0;
    nmis = 0;
    rst = 1'b1;
    dif.din = '0;
    dif.in_en = 1'b0;
    dif.clr = 1'b0;

    // Traffic during reset must be ignored.
    @(negedge clk);
    dif.din = 16'sd123;
    dif.in_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset", 0, 1'b0, 1'b0);
    dif.in_en = 1'b0;
    rst = 1'b0;

    cyc(100, 1'b1, 1'b0); chk("lat_k1", 0, 1'b0, 1'b0);
    cyc(0, 1'b0, 1'b0);   chk("lat_k2", 100, 1'b1, 1'b0);
    cyc(0, 1'b0, 1'b0);   chk("lat_hold", 100, 1'b0, 1'b0);
    cyc(0, 1'b0, 1'b1);
    cyc(0, 1'b0, 1'b0);   chk("clr_idle", 100, 1'b0, 1'b0);

`ifdef DIFF_INTEGRATOR_LEAK_EN
    leak_exp = '{1600, 1500, 1407, 1320, 1238};
    cyc(1600, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1'b1, 1'b0);
      chk("leak", leak_exp[i], 1'b1, 1'b0);
    end
`else
    // Ramp up then down: 5,10,...,50,45,...,0
    for (int i = 0; i <= 20; i++) begin
      cyc((i < 10) ? 5 : -5, (i < 20), 1'b0);
      if (i >= 1) begin
        exp_v = (i - 1 < 10) ? 5 * i : 50 - 5 * (i - 10);
        chk("ramp", exp_v, 1'b1, 1'b0);
      end
    end

    pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    gap_exp = '{7, 7, 14, 14, 21};
    for (int i = 0; i < 6; i++) begin
      cyc(7, pat[i], 1'b0);
      if (i >= 1) chk("gaps", gap_exp[i-1], pat[i-1], 1'b0);
    end
    cyc(0, 1'b0, 1'b1);

    // Saturation: output rails after 2 samples, accumulator rails at 2^23-1.
    for (int i = 0; i < 300; i++) begin
      cyc(32767, 1'b1, 1'b0);
      if (i >= 1) chk("sat_up", 32767, 1'b1, (i >= 2));
    end
    for (int j = 0; j < 256; j++) begin
      cyc(-32768, 1'b1, 1'b0);
      if (j == 0) chk("sat_up_last", 32767, 1'b1, 1'b1);
      if (j == 255) chk("sat_rail", 32767, 1'b1, 1'b1);
    end
    cyc(0, 1'b0, 1'b0); chk("sat_leave", -1, 1'b1, 1'b1);
    cyc(0, 1'b0, 1'b1); chk("sat_clr", -1, 1'b0, 1'b0);

    cyc(250, 1'b1, 1'b0);
    cyc(250, 1'b1, 1'b0); chk("acc_250", 250, 1'b1, 1'b0);
    cyc(20, 1'b1, 1'b0);  chk("acc_500", 500, 1'b1, 1'b0);
    cyc(3, 1'b1, 1'b1);   chk("clr_coll", 0, 1'b1, 1'b0);
    cyc(0, 1'b0, 1'b0);   chk("clr_stage1", 3, 1'b1, 1'b0);
`endif

    cyc(0, 1'b0, 1'b1);
    cyc(10, 1'b1, 1'b0);
    cyc(10, 1'b1, 1'b0); chk("pre_arst", 10, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1 chk("arst", 0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    cyc(0, 1'b0, 1'b0); chk("post_rst_en", 0, 1'b0, 1'b0);
    cyc(5, 1'b1, 1'b0);
    cyc(0, 1'b0, 1'b0); chk("post_rst_acc", 5, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
